serial_paralelo_rx: RTL and testbench

- Receive-side deserializer and comma aligner in phy_rx.
- Sits directly upstream of the idle/active symbol stage and produces its `active` input.
- Shifts in one serial bit per clk_32f cycle and finds the byte boundary by searching for the COM symbol.
- After BC_COUNT consecutive aligned COM bytes it asserts `active`; from then on it delivers each received byte in parallel with a valid flag.

---
 rtl/serial_paralelo_rx.sv | 141 ++++++++++++++
 tb/tb_serial_paralelo_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
//
// Receive-side deserializer and comma aligner. One serial bit is shifted in
// per clk_32f rising edge (MSB first). The byte boundary is found by sliding
// an 8-bit window over the stream until it equals COMMA. The receiver then
// checks that COMMA repeats at every byte boundary. After BC_COUNT consecutive
// aligned COMMA bytes it enters ACTIVE and stays there until reset. In ACTIVE
// every completed byte is presented on data_out for 8 cycles, with valid_out
// flagging non-COMMA bytes.
//
// Parameters:
//   COMMA     alignment / idle symbol (default 8'hBC)
//   BC_COUNT  consecutive aligned COMMA bytes needed for ACTIVE (1..15)
//
// Ports:
//   clk_32f    in   bit-rate clock, all state changes on its rising edge
//   reset_L    in   asynchronous active-low reset
//   data_in    in   serial data, MSB first
//   data_out   out  [7:0] last completed byte (updates only in ACTIVE)
//   valid_out  out  high while data_out holds a non-COMMA byte in ACTIVE
//   active     out  high once alignment has completed
//
// Handshake: there is no back-pressure. data_out/valid_out are a
// valid-only stream: a byte is offered for exactly 8 cycles, starting the
// cycle after the edge that sampled its last bit, and valid_out is the only
// qualifier. The FSM state is held in r_state for observation.
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ALIGNED = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t     r_state;
  // Only the 7 most recent bits need storing; the window's 8th bit is the
  // bit arriving this cycle.
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_bc_cnt;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_active;

  logic [7:0] w_window;
  logic       w_is_comma;
  logic       w_boundary;
  logic [3:0] w_bc_inc;
  logic [3:0] w_bc_target;

  // Every decision uses the window that includes the bit sampled this edge.
  assign w_window    = {r_shift, data_in};
  assign w_is_comma  = (w_window == COMMA);
  assign w_boundary  = (r_bit_cnt == 3'd7);
  assign w_bc_inc    = r_bc_cnt + 4'd1;
  assign w_bc_target = 4'(BC_COUNT);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_SEARCH;
      r_shift     <= 7'd0;
      r_bit_cnt   <= 3'd0;
      r_bc_cnt    <= 4'd0;
      r_data_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_shift <= w_window[6:0];
      case (r_state)
        ST_SEARCH: begin
          // Slide bit by bit; the boundary counter only starts once locked.
          r_bit_cnt <= 3'd0;
          if (w_is_comma) begin
            r_bc_cnt <= 4'd1;
            if (w_bc_target == 4'd1) begin
              r_state     <= ST_ACTIVE;
              r_active    <= 1'b1;
              r_data_out  <= COMMA;
              r_valid_out <= 1'b0;
            end else begin
              r_state <= ST_ALIGNED;
            end
          end
        end

        ST_ALIGNED: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          // COMMA seen at a non-boundary offset is deliberately ignored.
          if (w_boundary) begin
            if (w_is_comma) begin
              r_bc_cnt <= w_bc_inc;
              if (w_bc_inc == w_bc_target) begin
                r_state     <= ST_ACTIVE;
                r_active    <= 1'b1;
                r_data_out  <= COMMA;
                r_valid_out <= 1'b0;
              end
            end else begin
              // Any bad byte restarts the consecutive count from scratch.
              r_state   <= ST_SEARCH;
              r_bc_cnt  <= 4'd0;
              r_bit_cnt <= 3'd0;
            end
          end
        end

        ST_ACTIVE: begin
          // No loss-of-sync exit: only reset leaves ACTIVE.
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            r_data_out  <= w_window;
            r_valid_out <= !w_is_comma;
          end
        end

        default: begin
          r_state   <= ST_SEARCH;
          r_bit_cnt <= 3'd0;
          r_bc_cnt  <= 4'd0;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx
//
// Directed bench for serial_paralelo_rx. Two instances share the serial input
// and reset: dut0 with the default BC_COUNT=4 and dut1 with BC_COUNT=1.
// Inputs are driven right after a clock edge (or a negedge) and outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx;

  logic       clk_32f;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out0;
  logic       valid_out0;
  logic       active0;
  logic [7:0] data_out1;
  logic       valid_out1;
  logic       active1;

  int checks = 0;
  int errors = 0;

  serial_paralelo_rx #(.COMMA(8'hBC), .BC_COUNT(4)) dut0 (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_out  (data_out0),
    .valid_out (valid_out0),
    .active    (active0)
  );

  serial_paralelo_rx #(.COMMA(8'hBC), .BC_COUNT(1)) dut1 (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_out  (data_out1),
    .valid_out (valid_out1),
    .active    (active1)
  );

  // Clock / reset
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Drivers
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    data_in = 1'b0;
    #2;
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [7:0] b;
    reset_L = 1'b0;
    data_in = 1'b0;
    #2;
    checks++; if (active0 !== 1'b0) begin errors++; $display("FAIL reset_active0: got %b expected 0", active0); end
    checks++; if (valid_out0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b expected 0", valid_out0); end
    checks++; if (data_out0 !== 8'h00) begin errors++; $display("FAIL reset_data0: got %h expected 00", data_out0); end
    checks++; if (active1 !== 1'b0) begin errors++; $display("FAIL reset_active1: got %b expected 0", active1); end
    checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL reset_data1: got %h expected 00", data_out1); end
    // Clocking COMMA while reset is held must not move anything.
    b = 8'hBC;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    checks++; if (active1 !== 1'b0) begin errors++; $display("FAIL reset_held_active1: got %b expected 0", active1); end
    checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL reset_held_data1: got %h expected 00", data_out1); end
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  // 4 x BC from bit 0: active must rise exactly on edge 32.
  task automatic test_align_bit0();
    logic [7:0] b;
    logic       exp_act;
    int         n;
    do_reset();
    b = 8'hBC;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        n++;
        exp_act = (n >= 32);
        checks++; if (active0 !== exp_act) begin errors++; $display("FAIL align0_active edge %0d: got %b expected %b", n, active0, exp_act); end
        if (n < 32) begin
          checks++; if (data_out0 !== 8'h00) begin errors++; $display("FAIL align0_data_pre edge %0d: got %h expected 00", n, data_out0); end
        end
      end
    end
    checks++; if (data_out0 !== 8'hBC) begin errors++; $display("FAIL align0_data: got %h expected bc", data_out0); end
    checks++; if (valid_out0 !== 1'b0) begin errors++; $display("FAIL align0_valid: got %b expected 0", valid_out0); end
  endtask

  // Continues from ACTIVE: each byte appears on its 8th bit, previous held 7.
  task automatic test_stream();
    logic [7:0] bytes [5];
    logic       vals  [5];
    logic [7:0] prev_d;
    logic       prev_v;
    logic [7:0] b;
    bytes[0] = 8'h7C; vals[0] = 1'b1;
    bytes[1] = 8'hA5; vals[1] = 1'b1;
    bytes[2] = 8'hBC; vals[2] = 1'b0;
    bytes[3] = 8'hFF; vals[3] = 1'b1;
    bytes[4] = 8'h00; vals[4] = 1'b1;
    prev_d = 8'hBC;
    prev_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b = bytes[k];
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        if (i != 0) begin
          checks++; if (data_out0 !== prev_d) begin errors++; $display("FAIL stream_hold byte %0d bit %0d: got %h expected %h", k, i, data_out0, prev_d); end
          checks++; if (valid_out0 !== prev_v) begin errors++; $display("FAIL stream_hold_valid byte %0d bit %0d: got %b expected %b", k, i, valid_out0, prev_v); end
        end
      end
      checks++; if (data_out0 !== bytes[k]) begin errors++; $display("FAIL stream_data byte %0d: got %h expected %h", k, data_out0, bytes[k]); end
      checks++; if (valid_out0 !== vals[k]) begin errors++; $display("FAIL stream_valid byte %0d: got %b expected %b", k, valid_out0, vals[k]); end
      checks++; if (active0 !== 1'b1) begin errors++; $display("FAIL stream_active byte %0d: got %b expected 1", k, active0); end
      prev_d = bytes[k];
      prev_v = vals[k];
    end
  endtask

  // 3 junk bits 101 then 4 x BC: lock at offset 3, active on edge 35.
  task automatic test_offset();
    logic [2:0] junk;
    logic [7:0] b;
    logic       exp_act;
    int         n;
    do_reset();
    junk = 3'b101;
    n = 0;
    for (int i = 2; i >= 0; i--) begin
      send_bit(junk[i]);
      n++;
    end
    b = 8'hBC;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        n++;
        exp_act = (n >= 35);
        checks++; if (active0 !== exp_act) begin errors++; $display("FAIL offset_active edge %0d: got %b expected %b", n, active0, exp_act); end
      end
    end
    checks++; if (data_out0 !== 8'hBC) begin errors++; $display("FAIL offset_data: got %h expected bc", data_out0); end
    checks++; if (valid_out0 !== 1'b0) begin errors++; $display("FAIL offset_valid: got %b expected 0", valid_out0); end
  endtask

  // 3 x BC, 55, 4 x BC: the 55 restarts the count, active on edge 64.
  task automatic test_restart();
    logic [7:0] seq [8];
    logic [7:0] b;
    logic       exp_act;
    int         n;
    seq[0] = 8'hBC; seq[1] = 8'hBC; seq[2] = 8'hBC; seq[3] = 8'h55;
    seq[4] = 8'hBC; seq[5] = 8'hBC; seq[6] = 8'hBC; seq[7] = 8'hBC;
    do_reset();
    n = 0;
    for (int k = 0; k < 8; k++) begin
      b = seq[k];
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        n++;
        exp_act = (n >= 64);
        checks++; if (active0 !== exp_act) begin errors++; $display("FAIL restart_active edge %0d: got %b expected %b", n, active0, exp_act); end
      end
    end
    checks++; if (data_out0 !== 8'hBC) begin errors++; $display("FAIL restart_data: got %h expected bc", data_out0); end
  endtask

  // While ACTIVE with a valid byte shown, reset mid-byte between edges.
  task automatic test_midbyte_reset();
    logic [7:0] b;
    b = 8'h3C;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    checks++; if (valid_out0 !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b expected 1", valid_out0); end
    checks++; if (data_out0 !== 8'h3C) begin errors++; $display("FAIL midreset_pre_data: got %h expected 3c", data_out0); end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    checks++; if (active0 !== 1'b0) begin errors++; $display("FAIL midreset_active: got %b expected 0", active0); end
    checks++; if (valid_out0 !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", valid_out0); end
    checks++; if (data_out0 !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h expected 00", data_out0); end
    @(negedge clk_32f);
    reset_L = 1'b1;
    b = 8'hBC;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      if (k == 2) begin
        checks++; if (active0 !== 1'b0) begin errors++; $display("FAIL realign_early: got %b expected 0", active0); end
      end
    end
    checks++; if (active0 !== 1'b1) begin errors++; $display("FAIL realign_active: got %b expected 1", active0); end
    checks++; if (data_out0 !== 8'hBC) begin errors++; $display("FAIL realign_data: got %h expected bc", data_out0); end
  endtask

  // BC_COUNT=1: junk 01101 then one BC -> active on edge 13.
  task automatic test_bc1();
    logic [4:0] junk;
    logic [7:0] b;
    logic       exp_act;
    int         n;
    do_reset();
    junk = 5'b01101;
    n = 0;
    for (int i = 4; i >= 0; i--) begin
      send_bit(junk[i]);
      n++;
    end
    b = 8'hBC;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      n++;
      exp_act = (n >= 13);
      checks++; if (active1 !== exp_act) begin errors++; $display("FAIL bc1_active edge %0d: got %b expected %b", n, active1, exp_act); end
    end
    checks++; if (data_out1 !== 8'hBC) begin errors++; $display("FAIL bc1_data: got %h expected bc", data_out1); end
    checks++; if (valid_out1 !== 1'b0) begin errors++; $display("FAIL bc1_valid: got %b expected 0", valid_out1); end
    checks++; if (active0 !== 1'b0) begin errors++; $display("FAIL bc1_dut0_active: got %b expected 0", active0); end
    b = 8'h3C;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    checks++; if (data_out1 !== 8'h3C) begin errors++; $display("FAIL bc1_next_data: got %h expected 3c", data_out1); end
    checks++; if (valid_out1 !== 1'b1) begin errors++; $display("FAIL bc1_next_valid: got %b expected 1", valid_out1); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_align_bit0();
    test_stream();
    test_offset();
    test_restart();
    test_midbyte_reset();
    test_bc1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
